// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receiver for the host-link 8N2 serial line with a
// first-word-fall-through byte FIFO and inter-byte gap detection.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-high reset
//   rxd           asynchronous serial input, idles high
//   rd_en         pop the head byte (ignored while empty)
//   rd_data       FIFO head, valid while !empty
//   empty, full   FIFO status; count = bytes held
//   frame_err     1-clk pulse: stop bit sampled low
//   overrun       1-clk pulse: good byte dropped because FIFO was full
//   break_det     level: line held low through a whole frame, until it rises
//   idle          level: line high for IDLE_BITS bit-times
//   end_of_packet 1-clk pulse on idle rising when a byte arrived since idle fell
//
// Read handshake: a byte is consumed on every clk where rd_en && !empty;
// rd_data always shows the head byte while !empty, and the next byte appears
// the clk after a pop. rd_en while empty has no effect.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 921600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int IDLE_BITS  = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rxd,
  input  logic                              rd_en,
  output logic [7:0]                        rd_data,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH):0]       count,
  output logic                              frame_err,
  output logic                              overrun,
  output logic                              break_det,
  output logic                              idle,
  output logic                              end_of_packet
);

  // Tick generator: 24-bit phase accumulator, increment rounded in 64-bit
  // arithmetic. When the tick rate equals the clock the increment would not
  // fit, so tick is simply held high.
  localparam int          ACC_W       = 24;
  localparam logic [63:0] TICK_RATE   = 64'(BAUD) * 64'(OVERSAMPLE);
  localparam logic [63:0] INC_WIDE    = ((TICK_RATE << ACC_W) + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ);
  localparam bit          TICK_ALWAYS = (INC_WIDE >= (64'd1 << ACC_W));
  localparam logic [ACC_W-1:0] INC    = TICK_ALWAYS ? '0 : INC_WIDE[ACC_W-1:0];

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam int M    = OVERSAMPLE / 2;
  localparam logic [PH_W-1:0] PH_S0   = PH_W'(M - 1);
  localparam logic [PH_W-1:0] PH_S1   = PH_W'(M);
  localparam logic [PH_W-1:0] PH_DEC  = PH_W'(M + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = ADDR_W + 1;
  localparam int GAP_MAX = IDLE_BITS * OVERSAMPLE;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic [ACC_W-1:0] acc;
  logic             accCarry;
  logic             tick;
  logic [1:0]       sync;
  logic             rxs;
  state_t           state, nextState;
  logic [PH_W-1:0]  ph;
  logic [2:0]       bitCnt;
  logic             s0, s1, maj;
  logic [7:0]       shiftReg;
  logic             pushReq, frameErrReq;
  logic             doPush, doPop;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wrPtr, rdPtr;
  logic [GAP_W-1:0] gap;
  logic             byteSeen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      accCarry <= 1'b0;
    end else begin
      {accCarry, acc} <= {1'b0, acc} + {1'b0, INC};
    end
  end
  assign tick = TICK_ALWAYS | accCarry;

  // Synchroniser resets high so a reset in mid-frame cannot look like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rxd};
  end
  assign rxs = sync[1];

  // Third sample is the live synchronised value at the decision phase.
  assign maj = (s0 & s1) | (s0 & rxs) | (s1 & rxs);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nextState;
  end

  // FSM: next state
  always_comb begin
    nextState = state;
    if (tick) begin
      case (state)
        S_IDLE:  if (!rxs) nextState = S_START;
        S_START: begin
          if (ph == PH_DEC && maj)  nextState = S_IDLE;
          else if (ph == PH_LAST)   nextState = S_DATA;
        end
        S_DATA:  if (ph == PH_LAST && bitCnt == 3'd7) nextState = S_STOP;
        S_STOP:  begin
          if (ph == PH_DEC) begin
            if (maj)                   nextState = S_IDLE;
            else if (shiftReg == 8'h00) nextState = S_BREAK;
            else                       nextState = S_IDLE;
          end
        end
        S_BREAK: if (rxs) nextState = S_IDLE;
        default: nextState = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    pushReq     = 1'b0;
    frameErrReq = 1'b0;
    break_det   = (state == S_BREAK);
    if (tick && state == S_STOP && ph == PH_DEC) begin
      pushReq     = maj;
      frameErrReq = !maj;
    end
  end

  // Bit-phase counter, majority samples, bit counter and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph       <= '0;
      bitCnt   <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      shiftReg <= '0;
    end else if (tick) begin
      if (state == S_IDLE || state == S_BREAK) ph <= '0;
      else if (ph == PH_LAST)                  ph <= '0;
      else                                     ph <= ph + PH_W'(1);
      if (ph == PH_S0) s0 <= rxs;
      if (ph == PH_S1) s1 <= rxs;
      if (state == S_START)                       bitCnt <= '0;
      else if (state == S_DATA && ph == PH_LAST)  bitCnt <= bitCnt + 3'd1;
      if (state == S_DATA && ph == PH_DEC) shiftReg <= {maj, shiftReg[7:1]};
    end
  end

  // FIFO. A push into a full FIFO still succeeds if the head is popped in
  // the same clk; otherwise the byte is dropped and overrun pulses.
  assign doPush = pushReq && (!full || rd_en);
  assign doPop  = rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (doPush) begin
      mem[wrPtr] <= shiftReg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= pushReq && full && !rd_en;
      frame_err <= frameErrReq;
      if (doPush) wrPtr <= wrPtr + ADDR_W'(1);
      if (doPop)  rdPtr <= rdPtr + ADDR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rdPtr];
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));

  // Gap counter and packet delimiting. byteSeen records any good byte
  // (stored or dropped) since idle last fell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap           <= '0;
      idle          <= 1'b1;
      end_of_packet <= 1'b0;
      byteSeen      <= 1'b0;
    end else begin
      end_of_packet <= 1'b0;
      if (tick) begin
        if (state != S_IDLE) begin
          gap <= '0;
          if (idle) begin
            idle     <= 1'b0;
            byteSeen <= 1'b0;
          end
        end else if (rxs && gap != GAP_W'(GAP_MAX)) begin
          gap <= gap + GAP_W'(1);
          if (gap == GAP_W'(GAP_MAX - 1) && !idle) begin
            idle          <= 1'b1;
            end_of_packet <= byteSeen;
          end
        end
      end
      if (pushReq) byteSeen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo with the tick running every clk (16 clk per bit).
module tb_uart_rx_fifo;
  localparam int BAUD     = 921600;
  localparam int OS       = 16;
  localparam int CLK_FREQ = BAUD * OS;
  localparam int DEPTH    = 16;
  localparam int IDLE_BITS = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty, full;
  logic [4:0] count;
  logic       frame_err, overrun, break_det, idle, end_of_packet;

  uart_rx_fifo #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .FIFO_DEPTH(DEPTH), .IDLE_BITS(IDLE_BITS)
  ) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count), .frame_err(frame_err),
    .overrun(overrun), .break_det(break_det), .idle(idle),
    .end_of_packet(end_of_packet)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0, ov_cnt = 0, eop_cnt = 0;
  int exp_fe = 0, exp_ov = 0;
  logic [7:0] exp_q[$];
  logic [18:0] rst_vec;
  localparam logic [18:0] RST_EXP = {8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};

  // pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (frame_err)     fe_cnt++;
    if (overrun)       ov_cnt++;
    if (end_of_packet) eop_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rxd = 1'b0;
    tk(OS);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tk(OS);
    end
    rxd = stop_ok;
    tk(OS);
    rxd = 1'b1;
    tk(OS);
  endtask

  // send a frame and update the reference model from the line rules
  task automatic model_rx(input logic [7:0] b, input bit stop_ok);
    send_byte(b, stop_ok);
    if (!stop_ok)                  exp_fe++;
    else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else                           exp_ov++;
  endtask

  task automatic pop_byte(output logic [7:0] d);
    d = rd_data;
    rd_en = 1'b1;
    tk(1);
    rd_en = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; rxd = 1'b1; rd_en = 1'b0;
    tk(3);
    rst_vec = {rd_data, empty, full, count, frame_err, overrun, break_det, idle};
    checks++;
    if (rst_vec !== RST_EXP) begin
      errors++; $display("FAIL reset_values: got %h want %h", rst_vec, RST_EXP);
    end
    rst = 1'b0;
    tk(4);
    checks++;
    if (idle !== 1'b1 || empty !== 1'b1) begin
      errors++; $display("FAIL post_reset: idle=%b empty=%b want 1 1", idle, empty);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d, e;
    int fe0 = fe_cnt, ov0 = ov_cnt;
    model_rx(8'hA5, 1'b1);
    checks++;
    if (empty !== 1'b0 || count !== 5'd1) begin
      errors++; $display("FAIL basic_first: empty=%b count=%0d want 0 1", empty, count);
    end
    model_rx(8'h3C, 1'b1);
    checks++;
    if (count !== 5'd2) begin
      errors++; $display("FAIL basic_count2: count=%0d want 2", count);
    end
    for (int i = 0; i < 2; i++) begin
      pop_byte(d);
      e = exp_q.pop_front();
      checks++;
      if (d !== e || count !== 5'(1 - i)) begin
        errors++; $display("FAIL basic_pop%0d: data=%h count=%0d want %h %0d", i, d, count, e, 1 - i);
      end
    end
    checks++;
    if (fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++; $display("FAIL basic_no_err: fe=%0d ov=%0d want 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] d, e;
    int fe0 = fe_cnt;
    rxd = 1'b0;
    tk(7);
    rxd = 1'b1;
    tk(2 * OS);
    model_rx(8'h55, 1'b1);
    checks++;
    if (count !== 5'd1) begin
      errors++; $display("FAIL glitch_count: count=%0d want 1", count);
    end
    pop_byte(d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e || empty !== 1'b1) begin
      errors++; $display("FAIL glitch_data: data=%h empty=%b want %h 1", d, empty, e);
    end
    checks++;
    if (fe_cnt != fe0) begin
      errors++; $display("FAIL glitch_no_fe: frame_err pulses=%0d want 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_framing();
    logic [7:0] d, e;
    int fe0 = fe_cnt;
    model_rx(8'h81, 1'b0);
    checks++;
    if (fe_cnt - fe0 != 1 || count !== 5'd0) begin
      errors++; $display("FAIL frame_81: fe=%0d count=%0d want 1 0", fe_cnt - fe0, count);
    end
    rxd = 1'b0;
    tk(20 * OS);
    checks++;
    if (break_det !== 1'b1 || fe_cnt - fe0 != 2) begin
      errors++; $display("FAIL break_hold: break_det=%b fe=%0d want 1 2", break_det, fe_cnt - fe0);
    end
    rxd = 1'b1;
    tk(4);
    checks++;
    if (break_det !== 1'b0) begin
      errors++; $display("FAIL break_release: break_det=%b want 0", break_det);
    end
    exp_fe += 1;
    tk(OS);
    model_rx(8'h12, 1'b1);
    pop_byte(d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++; $display("FAIL break_then_rx: data=%h want %h", d, e);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d, e;
    int ov0 = ov_cnt;
    int eov0 = exp_ov;
    for (int b = 0; b < 17; b++) begin
      model_rx(8'(b), 1'b1);
      if (b == 15) begin
        checks++;
        if (full !== 1'b1 || count !== 5'd16) begin
          errors++; $display("FAIL ovr_full: full=%b count=%0d want 1 16", full, count);
        end
      end
    end
    checks++;
    if (ov_cnt - ov0 != exp_ov - eov0 || count !== 5'd16) begin
      errors++; $display("FAIL ovr_pulse: overrun=%0d count=%0d want %0d 16", ov_cnt - ov0, count, exp_ov - eov0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      pop_byte(d);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin
        errors++; $display("FAIL ovr_pop%0d: data=%h want %h", i, d, e);
      end
    end
    // refill, then pop in exactly the clk the 17th byte is pushed:
    // 2 sync + 1 detect + 16 start + 128 data + 9 to the stop decision
    for (int b = 0; b < 16; b++) model_rx(8'(b), 1'b1);
    ov0 = ov_cnt;
    fork
      send_byte(8'h10, 1'b1);
      begin
        tk(156);
        d = rd_data;
        rd_en = 1'b1;
        tk(1);
        rd_en = 1'b0;
        checks++;
        if (count !== 5'd16) begin
          errors++; $display("FAIL simul_count: count=%0d want 16", count);
        end
      end
    join
    e = exp_q.pop_front();
    exp_q.push_back(8'h10);
    checks++;
    if (d !== e || ov_cnt != ov0 || count !== 5'd16) begin
      errors++; $display("FAIL simul_push_pop: head=%h ov=%0d count=%0d want %h 0 16", d, ov_cnt - ov0, count, e);
    end
    for (int i = 0; i < DEPTH; i++) begin
      pop_byte(d);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin
        errors++; $display("FAIL simul_pop%0d: data=%h want %h", i, d, e);
      end
    end
  endtask

  task automatic test_packet_gap();
    logic [7:0] d, e;
    int eop0;
    rxd = 1'b1;
    tk(14 * OS);
    eop0 = eop_cnt;
    for (int i = 0; i < 3; i++) model_rx(8'($urandom_range(0, 255)), 1'b1);
    checks++;
    if (idle !== 1'b0 || eop_cnt != eop0) begin
      errors++; $display("FAIL gap_busy: idle=%b eop=%0d want 0 0", idle, eop_cnt - eop0);
    end
    tk(IDLE_BITS * OS);
    checks++;
    if (idle !== 1'b1 || eop_cnt - eop0 != 1) begin
      errors++; $display("FAIL gap_eop: idle=%b eop=%0d want 1 1", idle, eop_cnt - eop0);
    end
    tk(IDLE_BITS * OS);
    checks++;
    if (idle !== 1'b1 || eop_cnt - eop0 != 1) begin
      errors++; $display("FAIL gap_no_second: idle=%b eop=%0d want 1 1", idle, eop_cnt - eop0);
    end
    for (int i = 0; i < 3; i++) begin
      pop_byte(d);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin
        errors++; $display("FAIL gap_pop%0d: data=%h want %h", i, d, e);
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] d, e;
    int fe0;
    model_rx(8'h77, 1'b1);
    fork
      send_byte(8'hF0, 1'b1);
      begin
        tk(OS + 4 * OS + 8);
        rst = 1'b1;
        tk(2);
        rst_vec = {rd_data, empty, full, count, frame_err, overrun, break_det, idle};
        checks++;
        if (rst_vec !== RST_EXP) begin
          errors++; $display("FAIL midbyte_reset: got %h want %h", rst_vec, RST_EXP);
        end
        rst = 1'b0;
        exp_q.delete();
        fe0 = fe_cnt;
      end
    join
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || fe_cnt != fe0) begin
      errors++; $display("FAIL midbyte_after: count=%0d empty=%b fe=%0d want 0 1 0", count, empty, fe_cnt - fe0);
    end
    tk(OS);
    model_rx(8'h0F, 1'b1);
    pop_byte(d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++; $display("FAIL midbyte_next: data=%h want %h", d, e);
    end
  endtask

  task automatic test_random();
    logic [7:0] d, e;
    int fe0 = fe_cnt, ov0 = ov_cnt;
    int efe0 = exp_fe, eov0 = exp_ov;
    int npop;
    for (int it = 0; it < 24; it++) begin
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        if (exp_q.size() > 0) begin
          pop_byte(d);
          e = exp_q.pop_front();
          checks++;
          if (d !== e) begin
            errors++; $display("FAIL rand_pop it%0d: data=%h want %h", it, d, e);
          end
        end
      end
      model_rx(8'($urandom_range(0, 255)), $urandom_range(0, 9) != 0);
      tk($urandom_range(0, 20));
    end
    checks++;
    if (fe_cnt - fe0 != exp_fe - efe0 || ov_cnt - ov0 != exp_ov - eov0) begin
      errors++; $display("FAIL rand_errs: fe=%0d ov=%0d want %0d %0d",
                         fe_cnt - fe0, ov_cnt - ov0, exp_fe - efe0, exp_ov - eov0);
    end
    checks++;
    if (count !== 5'(exp_q.size())) begin
      errors++; $display("FAIL rand_count: count=%0d want %0d", count, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      pop_byte(d);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin
        errors++; $display("FAIL rand_drain: data=%h want %h", d, e);
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL rand_empty: empty=%b want 1", empty);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_packet_gap();
    test_reset_mid_byte();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
